mersenne_mult_seq: RTL and testbench

Sequential, constant-time shift-add multiplier that produces the 26-bit unreduced product consumed by the mod-8191 (2^13−1) reduction stage. It accepts two 13-bit operands with a start/done handshake and computes one multiplier bit per cycle. It takes exactly WIDTH cycles regardless of operand values, so operand-dependent timing cannot leak into side-channel traces. The registered `naive` output feeds the reduction stage's 26-bit input directly.

---
 rtl/mersenne_pkg.sv | 20 ++
 rtl/mersenne_mult_seq_if.sv | 29 ++
 rtl/mersenne_mult_seq.sv | 93 +++++++++
 tb/tb_mersenne_mult_seq.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mersenne_pkg.sv
`default_nettype none
// ============================================================================
// mersenne_pkg
// Shared constants and state encoding for the mod-(2^13-1) arithmetic blocks.
// Revision: 1.0
// ============================================================================
package mersenne_pkg;

  localparam int MERS_W = 13;
  localparam logic [MERS_W-1:0] MERS_P = 13'h1FFF;
  localparam int PROD_W = 2 * MERS_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mers_state_e;

endpackage : mersenne_pkg
`default_nettype wire

// File: rtl/mersenne_mult_seq_if.sv
`default_nettype none
// ============================================================================
// mersenne_mult_seq_if
// Start/done handshake and operand/product bus of the sequential multiplier.
// Revision: 1.0
// ============================================================================
interface mersenne_mult_seq_if #(
  parameter int WIDTH = 13
);

  logic               start;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] naive;

  modport master (
    output start, opa, opb,
    input  busy, done, naive
  );

  modport slave (
    input  start, opa, opb,
    output busy, done, naive
  );

endinterface : mersenne_mult_seq_if
`default_nettype wire

// File: rtl/mersenne_mult_seq.sv
`default_nettype none
// ============================================================================
// mersenne_mult_seq
// Constant-time shift-add multiplier producing the unreduced 2*WIDTH product.
// Revision: 1.0
// ============================================================================
module mersenne_mult_seq
  import mersenne_pkg::*;
#(
  parameter int WIDTH = MERS_W
) (
  input  wire logic            clk,
  input  wire logic            rst,
  mersenne_mult_seq_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mers_state_e      state_q,  state_d;
  logic [PW-1:0]    mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q,    acc_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [PW-1:0]    naive_q,  naive_d;

  logic [PW-1:0]    addend;
  logic [PW-1:0]    sum;

  // Adder is exercised every RUN cycle; only the operand select depends on data.
  assign addend = mplier_q[0] ? mcand_q : '0;
  assign sum    = acc_q + addend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      naive_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      naive_q  <= naive_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    naive_d  = naive_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          mcand_d  = {{WIDTH{1'b0}}, bus.opa};
          mplier_d = bus.opb;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == LAST_CNT) begin
          naive_d = sum;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.naive = naive_q;

endmodule : mersenne_mult_seq
`default_nettype wire

// File: tb/tb_mersenne_mult_seq.sv
`default_nettype none
// ============================================================================
// tb_mersenne_mult_seq
// Directed self-checking bench for the sequential shift-add multiplier.
// Revision: 1.0
// ============================================================================
module tb_mersenne_mult_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mersenne_mult_seq_if #(.WIDTH(13)) bus ();

  mersenne_mult_seq #(.WIDTH(13)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one multiply from an idle state and checks timing and result.
  task automatic do_mult(input string tag, input logic [12:0] a, input logic [12:0] b,
                         input logic [25:0] exp);
    int          lat;
    int          bcnt;
    logic [25:0] prev;
    prev      = bus.naive;
    bus.start = 1'b1;
    bus.opa   = a;
    bus.opb   = b;
    tick();
    bus.start = 1'b0;
    lat  = 1;
    bcnt = 0;
    check_eq({tag, "_hold"}, 32'(bus.naive), 32'(prev));
    while (!bus.done && lat < 40) begin
      if (bus.busy) bcnt++;
      if (bus.busy && bus.done) check_eq({tag, "_excl"}, 32'(1), 32'(0));
      tick();
      lat++;
    end
    check_eq({tag, "_lat"},   32'(lat),       32'(14));
    check_eq({tag, "_busy"},  32'(bcnt),      32'(13));
    check_eq({tag, "_naive"}, 32'(bus.naive), 32'(exp));
    check_eq({tag, "_bz"},    32'(bus.busy),  32'(0));
    tick();
    check_eq({tag, "_pulse"}, 32'(bus.done),  32'(0));
    check_eq({tag, "_keep"},  32'(bus.naive), 32'(exp));
  endtask

  initial begin
    int          lat;
    int          dcnt;
    logic [25:0] seen;

    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.opa   = '0;
    bus.opb   = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_eq("rst_busy",  32'(bus.busy),  32'(0));
    check_eq("rst_done",  32'(bus.done),  32'(0));
    check_eq("rst_naive", 32'(bus.naive), 32'(0));
    tick();

    do_mult("m3x5",  13'd3,     13'd5,     26'h000000F);
    do_mult("mmax",  13'h1FFF,  13'h1FFF,  26'h3FFC001);
    do_mult("mbz",   13'h1FFF,  13'h0000,  26'h0000000);
    do_mult("maz",   13'h0000,  13'h1FFF,  26'h0000000);

    // Start while busy: second request in cycle 5 must be ignored.
    bus.start = 1'b1; bus.opa = 13'd7; bus.opb = 13'd9;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.start = 1'b1; bus.opa = 13'd1; bus.opb = 13'd1;
    tick();
    bus.start = 1'b0;
    dcnt = 0;
    seen = '0;
    for (int i = 0; i < 25; i++) begin
      if (bus.done) begin
        dcnt++;
        seen = bus.naive;
      end
      tick();
    end
    check_eq("sb_ndone", 32'(dcnt), 32'(1));
    check_eq("sb_naive", 32'(seen), 32'(63));

    // Back-to-back: new start presented during the DONE cycle.
    bus.start = 1'b1; bus.opa = 13'd2; bus.opb = 13'h1FFF;
    tick();
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin tick(); lat++; end
    check_eq("b2b_lat1",  32'(lat),               32'(14));
    check_eq("b2b_n1",    32'(bus.naive),         32'(26'h3FFE));
    check_eq("b2b_red1",  32'(bus.naive % 8191),  32'(0));
    bus.start = 1'b1; bus.opa = 13'h100; bus.opb = 13'h020;
    tick();
    bus.start = 1'b0;
    check_eq("b2b_acc",   32'(bus.busy),          32'(1));
    check_eq("b2b_hold",  32'(bus.naive),         32'(26'h3FFE));
    lat = 1;
    while (!bus.done && lat < 40) begin tick(); lat++; end
    check_eq("b2b_gap",   32'(lat),               32'(14));
    check_eq("b2b_n2",    32'(bus.naive),         32'(26'h2000));
    check_eq("b2b_red2",  32'(bus.naive % 8191),  32'(1));
    tick();

    // Reset in RUN cycle 6 aborts the operation.
    bus.start = 1'b1; bus.opa = 13'h123; bus.opb = 13'h456;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    check_eq("rr_run", 32'(bus.busy), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rr_busy",  32'(bus.busy),  32'(0));
    check_eq("rr_done",  32'(bus.done),  32'(0));
    check_eq("rr_naive", 32'(bus.naive), 32'(0));
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done || bus.busy) dcnt++;
      tick();
    end
    check_eq("rr_quiet", 32'(dcnt), 32'(0));

    do_mult("post", 13'h123, 13'h456, 26'h004EDC2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mersenne_mult_seq
`default_nettype wire
